// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch-stage control and IF/ID payload bundle
interface if_fetch_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic [15:0] instr_o;
  logic [15:0] pc_o;
  logic [15:0] pc_next_o;
  logic        valid_o;
  logic        halted_o;

  // Fetch stage side: takes control, drives the IF/ID payload.
  modport master (
    input  stall_i, redirect_i, redirect_pc_i,
    output instr_o, pc_o, pc_next_o, valid_o, halted_o
  );

  // Pipeline side: drives control, consumes the IF/ID payload.
  modport slave (
    output stall_i, redirect_i, redirect_pc_i,
    input  instr_o, pc_o, pc_next_o, valid_o, halted_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with ROM, stall/redirect and halt FSM (optional FETCH_CNT_EN fetch counter)
module if_fetch_stage #(
  parameter logic [15:0]              RESET_PC    = 16'h0000,
  parameter int                       IMEM_DEPTH  = 256,
  parameter                           IMEM_FILE   = "imem.hex",
  parameter logic [16*IMEM_DEPTH-1:0] IMEM_INIT   = '0,
  parameter logic [15:0]              HALT_OPCODE = 16'hFFFF
) (
  input  logic                C,
  input  logic                R,
  if_fetch_stage_if.master    bus
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]         fetch_cnt_o
`endif
);

  // IMEM_FILE names the hex image that the memory-init flow turns into
  // IMEM_INIT; only the name travels with the block.
  localparam int unused_imem_file_bits = $bits(IMEM_FILE);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_o_q, pc_o_d;
  logic [15:0] pc_next_q, pc_next_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [15:0] imem [IMEM_DEPTH];
  logic [14:0] word_idx;
  logic        in_range;
  logic [15:0] rom_word;
  logic [15:0] pc_plus2;
  logic [15:0] redirect_tgt;

  // ROM contents are fixed at elaboration.
  for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_imem
    assign imem[i] = IMEM_INIT[16*i +: 16];
  end

  assign word_idx     = pc_q[15:1];
  assign in_range     = ({17'd0, word_idx} < 32'(IMEM_DEPTH));
  // Addresses past the ROM read as NOP so no X ever reaches IF/ID.
  assign rom_word     = in_range ? imem[word_idx[AW-1:0]] : 16'h0000;
  assign pc_plus2     = pc_q + 16'd2;
  assign redirect_tgt = bus.redirect_pc_i & 16'hFFFE;

  // State register.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next register values; redirect beats stall beats fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_o_d    = pc_o_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        valid_d = 1'b0;
        if (bus.redirect_i) begin
          pc_d = redirect_tgt;
        end
      end
      S_RUN: begin
        if (bus.redirect_i) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
        end else if (!bus.stall_i) begin
          instr_d   = rom_word;
          pc_o_d    = pc_q;
          pc_next_d = pc_plus2;
          valid_d   = 1'b1;
          pc_d      = pc_plus2;
          if (rom_word == HALT_OPCODE) begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (bus.redirect_i) begin
          state_d  = S_RUN;
          pc_d     = redirect_tgt;
          halted_d = 1'b0;
        end else begin
          halted_d = 1'b1;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // PC and IF/ID payload registers.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      pc_q      <= RESET_PC;
      instr_q   <= 16'h0000;
      pc_o_q    <= 16'h0000;
      pc_next_q <= 16'h0002;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_o_q    <= pc_o_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.instr_o   = instr_q;
  assign bus.pc_o      = pc_o_q;
  assign bus.pc_next_o = pc_next_q;
  assign bus.valid_o   = valid_q;
  assign bus.halted_o  = halted_q;

`ifdef FETCH_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic        cnt_en;

  // Same condition that loads valid_o with 1 in the next-state logic.
  assign cnt_en = (state_q == S_RUN) && !bus.redirect_i && !bus.stall_i;

  // Saturating count of real fetches.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      fetch_cnt_q <= 16'h0000;
    end else if (cnt_en && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
